// File: rtl/requant_pkg.sv
// Shared types, derived widths and the round/shift/saturate helper for requant_writeback.
package requant_pkg;

  localparam int ACC_W   = 32;
  localparam int MULT_W  = 16;
  localparam int OUT_W   = 8;
  localparam int SHIFT_W = 5;
  localparam int SUM_W   = ACC_W + 1;
  localparam int PROD_W  = ACC_W + MULT_W + 2;

  localparam logic signed [PROD_W-1:0] OUT_MAX = PROD_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [PROD_W-1:0] OUT_MIN = PROD_W'(-(2 ** (OUT_W - 1)));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic                    sat;
    logic signed [OUT_W-1:0] data;
  } rs_t;

  // Round half up, then arithmetic shift, then clip to the signed output range.
  function automatic rs_t round_shift_sat(input logic signed [PROD_W-1:0] prod,
                                          input logic [SHIFT_W-1:0]       sh);
    logic signed [PROD_W-1:0] half;
    logic signed [PROD_W-1:0] shd;
    rs_t                      res;
    half = '0;
    if (sh != '0) half = PROD_W'(1) << (sh - SHIFT_W'(1));
    shd = (prod + half) >>> sh;
    if (shd > OUT_MAX) begin
      res.sat  = 1'b1;
      res.data = OUT_MAX[OUT_W-1:0];
    end else if (shd < OUT_MIN) begin
      res.sat  = 1'b1;
      res.data = OUT_MIN[OUT_W-1:0];
    end else begin
      res.sat  = 1'b0;
      res.data = shd[OUT_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/requant_round_sat.sv
// Final requant stage: scale the biased sum, then round, shift and saturate.
module requant_round_sat
  import requant_pkg::*;
(
  input  logic signed [SUM_W-1:0]   i_sum,
  input  logic        [MULT_W-1:0]  i_scale,
  input  logic        [SHIFT_W-1:0] i_shift,
  output logic signed [OUT_W-1:0]   o_data,
  output logic                      o_sat
);

  logic signed [PROD_W-1:0] w_prod;
  rs_t                      w_rs;

  // Scale is unsigned; a zero MSB keeps it positive in the signed multiply.
  assign w_prod = PROD_W'(i_sum) * PROD_W'($signed({1'b0, i_scale}));
  assign w_rs   = round_shift_sat(w_prod, i_shift);
  assign o_data = w_rs.data;
  assign o_sat  = w_rs.sat;

endmodule

// File: rtl/requant_writeback.sv
// Bias-add, scale, round/saturate and write back one layer of accumulator results.
// Optional clip counter output sat_count is enabled with `define REQUANT_SAT_COUNT_EN.
module requant_writeback
  import requant_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_WIDTH   = ACC_W,
  parameter int OUT_WIDTH   = OUT_W,
  parameter int ADDR_WIDTH  = 10,
  parameter int MULT_WIDTH  = MULT_W,
  parameter int SHIFT_WIDTH = SHIFT_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_start,
  input  logic        [ADDR_WIDTH-1:0]  cfg_num_outputs,
  input  logic        [ADDR_WIDTH-1:0]  cfg_out_base_addr,
  input  logic        [MULT_WIDTH-1:0]  cfg_scale_mult,
  input  logic        [SHIFT_WIDTH-1:0] cfg_shift,
  input  logic                          in_valid,
  input  logic signed [ACC_WIDTH-1:0]   in_acc,
  output logic                          bias_rd_en,
  output logic        [ADDR_WIDTH-1:0]  bias_rd_addr,
  input  logic signed [DATA_WIDTH-1:0]  bias_rd_data,
  output logic                          out_wr_en,
  output logic        [ADDR_WIDTH-1:0]  out_wr_addr,
  output logic signed [OUT_WIDTH-1:0]   out_wr_data,
  output logic                          busy,
  output logic                          layer_done
`ifdef REQUANT_SAT_COUNT_EN
  ,
  output logic        [ADDR_WIDTH-1:0]  sat_count
`endif
);

  state_t                   r_state;
  logic                     r_busy;
  logic                     r_layer_done;
  logic [ADDR_WIDTH-1:0]    r_num;
  logic [ADDR_WIDTH-1:0]    r_base;
  logic [MULT_WIDTH-1:0]    r_scale;
  logic [SHIFT_WIDTH-1:0]   r_shift;
  logic [ADDR_WIDTH-1:0]    r_acc_cnt;
  logic [ADDR_WIDTH-1:0]    r_iss_cnt;
  logic [ADDR_WIDTH-1:0]    r_wr_cnt;

  logic                     r_vld_p1;
  logic                     r_vld_p2;
  logic signed [ACC_WIDTH-1:0] r_acc_p1;
  logic signed [SUM_W-1:0]  r_sum_p2;
  logic                     r_out_wr_en;
  logic [ADDR_WIDTH-1:0]    r_out_wr_addr;
  logic signed [OUT_WIDTH-1:0] r_out_wr_data;

  logic                     w_accept;
  logic [ADDR_WIDTH-1:0]    w_acc_cnt_nxt;
  logic [ADDR_WIDTH-1:0]    w_wr_cnt_nxt;
  logic signed [OUT_W-1:0]  w_rs_data;
  logic                     w_sat;

  assign w_accept      = (r_state == RUN) && in_valid && (r_acc_cnt != r_num);
  assign w_acc_cnt_nxt = r_acc_cnt + {{(ADDR_WIDTH-1){1'b0}}, w_accept};
  assign w_wr_cnt_nxt  = r_wr_cnt + {{(ADDR_WIDTH-1){1'b0}}, r_out_wr_en};

  assign bias_rd_en   = w_accept;
  assign bias_rd_addr = r_acc_cnt;
  assign out_wr_en    = r_out_wr_en;
  assign out_wr_addr  = r_out_wr_addr;
  assign out_wr_data  = r_out_wr_data;
  assign busy         = r_busy;
  assign layer_done   = r_layer_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_layer_done <= 1'b0;
      r_num        <= '0;
      r_base       <= '0;
      r_scale      <= '0;
      r_shift      <= '0;
      r_acc_cnt    <= '0;
      r_iss_cnt    <= '0;
      r_wr_cnt     <= '0;
    end else begin
      r_layer_done <= 1'b0;
      r_acc_cnt    <= w_acc_cnt_nxt;
      r_wr_cnt     <= w_wr_cnt_nxt;
      if (r_vld_p2) r_iss_cnt <= r_iss_cnt + ADDR_WIDTH'(1);
      case (r_state)
        IDLE: begin
          if (cfg_start) begin
            r_num     <= cfg_num_outputs;
            r_base    <= cfg_out_base_addr;
            r_scale   <= cfg_scale_mult;
            r_shift   <= cfg_shift;
            r_acc_cnt <= '0;
            r_iss_cnt <= '0;
            r_wr_cnt  <= '0;
            r_busy    <= 1'b1;
            r_state   <= RUN;
          end
        end
        RUN: begin
          if (w_acc_cnt_nxt == r_num) begin
            r_state <= DRAIN;
            // An empty layer has nothing to drain, so it completes right away.
            if (r_num == '0) r_layer_done <= 1'b1;
          end
        end
        DRAIN: begin
          if (w_wr_cnt_nxt == r_num) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_layer_done <= r_out_wr_en;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1      <= 1'b0;
      r_vld_p2      <= 1'b0;
      r_out_wr_en   <= 1'b0;
      r_out_wr_addr <= '0;
      r_out_wr_data <= '0;
    end else begin
      r_vld_p1    <= w_accept;
      r_vld_p2    <= r_vld_p1;
      r_out_wr_en <= r_vld_p2;
      if (r_vld_p2) begin
        r_out_wr_addr <= r_base + r_iss_cnt;
        r_out_wr_data <= w_rs_data;
      end
    end
  end

  // S1: capture accumulator; S2: add bias that arrives one cycle after the read.
  always_ff @(posedge clk) begin
    if (w_accept) r_acc_p1 <= in_acc;
    if (r_vld_p1) r_sum_p2 <= SUM_W'(r_acc_p1) + SUM_W'(bias_rd_data);
  end

  // S3: scale, round, shift and saturate feed the output registers.
  requant_round_sat u_round_sat (
    .i_sum   (r_sum_p2),
    .i_scale (r_scale),
    .i_shift (r_shift),
    .o_data  (w_rs_data),
    .o_sat   (w_sat)
  );

`ifdef REQUANT_SAT_COUNT_EN
  logic [ADDR_WIDTH-1:0] r_sat_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_cnt <= '0;
    end else if ((r_state == IDLE) && cfg_start) begin
      r_sat_cnt <= '0;
    end else if (r_vld_p2 && w_sat) begin
      r_sat_cnt <= r_sat_cnt + ADDR_WIDTH'(1);
    end
  end

  assign sat_count = r_sat_cnt;
`endif

endmodule

// File: doc/requant_writeback.md
Name: requant_writeback

Overview:
Downstream stage of the dot-product engine. Consumes each finished accumulator result (its `done` pulse plus 2*DATA_WIDTH result), adds a per-output bias, applies a fixed-point scale (multiply, rounding right shift), saturates to OUT_WIDTH and writes the value to the output activation memory at consecutive addresses. It sequences one layer of cfg_num_outputs results and pulses layer_done when the last write has retired.

Parameters:
DATA_WIDTH, 16, bias word width (same as token/weight width)
ACC_WIDTH, 32, accumulator input width (2*DATA_WIDTH)
OUT_WIDTH, 8, signed output activation width
ADDR_WIDTH, 10, bias/output memory address width
MULT_WIDTH, 16, unsigned scale multiplier width
SHIFT_WIDTH, 5, right-shift amount width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_start  in  1  pulse: latch cfg_*, begin layer (honoured only in IDLE)
cfg_num_outputs  in  ADDR_WIDTH  results expected this layer
cfg_out_base_addr  in  ADDR_WIDTH  first output write address
cfg_scale_mult  in  MULT_WIDTH  unsigned scale
cfg_shift  in  SHIFT_WIDTH  right shift 0..31
in_valid  in  1  result valid (driven from dot-product done)
in_acc  in  ACC_WIDTH  signed accumulator result
bias_rd_en  out  1  bias memory read strobe
bias_rd_addr  out  ADDR_WIDTH  bias index
bias_rd_data  in  DATA_WIDTH  signed bias, valid 1 cycle after read
out_wr_en  out  1  output memory write strobe
out_wr_addr  out  ADDR_WIDTH  output address
out_wr_data  out  OUT_WIDTH  saturated result
busy  out  1  high in RUN and DRAIN
layer_done  out  1  one-cycle pulse at layer end

Behaviour:
- Reset (async, rst_n low): state IDLE; out_wr_en, layer_done, busy, bias_rd_en = 0; out_wr_addr, out_wr_data, counters, pipeline valids = 0. A reset mid-layer discards all in-flight results; no write occurs after reset release.
- FSM IDLE -> RUN on cfg_start (config registered). RUN -> DRAIN in the cycle accepted count reaches cfg_num_outputs. DRAIN -> IDLE when write count equals cfg_num_outputs; layer_done pulses in the cycle after the last write. cfg_start outside IDLE is ignored.
- Accept: in_valid in RUN with accepted < num. Accepts one per cycle, back-to-back; no backpressure. in_valid in IDLE/DRAIN is dropped.
- bias_rd_en = accept (combinational); bias_rd_addr = accepted index (0-based).
- Pipeline, fixed latency 3. S1: register in_acc. S2: sum = in_acc + sign-extended bias (ACC_WIDTH+1 bits). S3: prod = sum * zero-extended scale (signed, ACC_WIDTH+MULT_WIDTH+2 bits); round = prod + (shift>0 ? 1<<(shift-1) : 0); arithmetic shift right by shift; saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. Result registered onto out_wr_*.
- in_valid at cycle t -> out_wr_en at t+3. out_wr_addr = base + write index, wraps modulo 2^ADDR_WIDTH.
- cfg_num_outputs = 0: RUN -> DRAIN next cycle, no writes, layer_done 2 cycles after cfg_start.

Optional Feature:
REQUANT_SAT_COUNT_EN: when defined, adds output sat_count [ADDR_WIDTH] counting writes that clipped this layer (clears on accepted cfg_start; holds after layer_done). When undefined, the port and counter are absent.

Decomposition:
- requant_pkg: state_t enum (IDLE, RUN, DRAIN), derived width localparams (SUM_W, PROD_W), and the round/shift/saturate function.
- One sub-module, requant_round_sat: combinational shift, round and saturate on S3. It is instantiated once.

Test Plan:
- num=1, acc=100, bias=0, scale=3, shift=2 -> write 75 at base, t+3; layer_done t+4.
- acc=-10, bias=0, scale=1, shift=2 -> -2 (round half up).
- acc=1000, bias=24, scale=1, shift=3 -> 128 clips to 127; sat_count=1 if enabled. acc=-100000, scale=1, shift=0 -> -128.
- num=4, base=0x3FE, 4 back-to-back inputs -> writes at 0x3FE, 0x3FF, 0x000, 0x001 in consecutive cycles; bias addrs 0..3.
- Extra 5th in_valid after num=4 accepted, plus cfg_start during RUN -> both ignored, exactly 4 writes.
- rst_n low one cycle after the 2nd of 3 inputs -> no out_wr_en after release, outputs 0, state IDLE.
